// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU op / funct codes,
// forwarding selects and the multiplier FSM state type.
package ex_pkg;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_ADD2  = 2'b11;

    localparam logic [2:0] FN_ADD = 3'b000;
    localparam logic [2:0] FN_SUB = 3'b001;
    localparam logic [2:0] FN_AND = 3'b010;
    localparam logic [2:0] FN_OR  = 3'b011;
    localparam logic [2:0] FN_SLT = 3'b100;
    localparam logic [2:0] FN_XOR = 3'b101;
    localparam logic [2:0] FN_MUL = 3'b110;
    localparam logic [2:0] FN_NOR = 3'b111;

    localparam logic [1:0] FWD_REG  = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    localparam logic [1:0] FWD_REG2 = 2'b11;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_BUSY = 1'b1
    } mul_state_t;

endpackage

// File: rtl/ex_mul_seq.sv
// Iterative shift-add multiplier, one partial product per BUSY cycle.
// The final step is presented combinationally on o_result during the
// last BUSY cycle (o_last) so the EX/MEM register can capture it on the
// edge that also returns the FSM to IDLE.
module ex_mul_seq
    import ex_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_busy,
    output logic              o_last,
    output logic [DATA_W-1:0] o_result
);

    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    mul_state_t        r_state;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] w_acc_next;

    // Accumulate the current partial product (multiplicand pre-shifted)
    always_comb begin
        w_acc_next = r_acc + (r_b[0] ? r_a : '0);
    end

    // FSM: latch operands on start, step until the last count, abort on flush
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= MUL_IDLE;
            r_count <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
        end else begin
            case (r_state)
                MUL_IDLE: begin
                    if (i_start && !i_flush) begin
                        r_state <= MUL_BUSY;
                        r_count <= '0;
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_acc   <= '0;
                    end
                end
                MUL_BUSY: begin
                    if (i_flush || (r_count == LAST_CNT)) begin
                        r_state <= MUL_IDLE;
                        r_count <= '0;
                    end else begin
                        r_count <= r_count + 1'b1;
                        r_a     <= r_a << 1;
                        r_b     <= r_b >> 1;
                        r_acc   <= w_acc_next;
                    end
                end
                default: r_state <= MUL_IDLE;
            endcase
        end
    end

    assign o_busy   = (r_state == MUL_BUSY);
    assign o_last   = (r_state == MUL_BUSY) && (r_count == LAST_CNT);
    assign o_result = w_acc_next;

endmodule

// File: rtl/ex_stage_pipe.sv
// Execute stage: forwarding muxes, ALU, branch-target adder, EX/MEM register.
// Optional iterative multiplier enabled by defining EX_MUL_EN; without it
// funct 110 yields 0 in one cycle and stall is tied low.
module ex_stage_pipe
    import ex_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_W  = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic              flush,
    input  logic [DATA_W-1:0] pc_next,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [DATA_W-1:0] imm,
    input  logic [REG_W-1:0]  rt_idx,
    input  logic [REG_W-1:0]  rd_idx,
    input  logic              alu_src,
    input  logic              reg_dest,
    input  logic [1:0]        alu_op,
    input  logic [1:0]        fwd_a,
    input  logic [1:0]        fwd_b,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [DATA_W-1:0] wb_result,
    output logic              stall,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_result,
    output logic [DATA_W-1:0] out_store_data,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_zero,
    output logic [DATA_W-1:0] out_branch_target
);

    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_fwd_b;
    logic [DATA_W-1:0] w_alu_b;
    logic [DATA_W-1:0] w_alu_res;
    logic [DATA_W-1:0] w_result;
    logic [DATA_W-1:0] w_branch;
    logic [2:0]        w_funct;
    logic              w_stall;

    logic              r_valid;
    logic [DATA_W-1:0] r_result;
    logic [DATA_W-1:0] r_store;
    logic [REG_W-1:0]  r_rd;
    logic              r_zero;
    logic [DATA_W-1:0] r_branch;

    assign w_funct  = imm[2:0];
    assign w_branch = pc_next + {imm[DATA_W-2:0], 1'b0};

    // Forwarding muxes and ALU B select
    always_comb begin
        case (fwd_a)
            FWD_WB:  w_op_a = wb_result;
            FWD_MEM: w_op_a = mem_result;
            default: w_op_a = rs_data;
        endcase
        case (fwd_b)
            FWD_WB:  w_fwd_b = wb_result;
            FWD_MEM: w_fwd_b = mem_result;
            default: w_fwd_b = rt_data;
        endcase
        w_alu_b = alu_src ? imm : w_fwd_b;
    end

    // ALU with funct decode; multiply yields 0 here and is overridden below
    always_comb begin
        w_alu_res = '0;
        case (alu_op)
            ALU_SUB:   w_alu_res = w_op_a - w_alu_b;
            ALU_FUNCT: begin
                case (w_funct)
                    FN_ADD:  w_alu_res = w_op_a + w_alu_b;
                    FN_SUB:  w_alu_res = w_op_a - w_alu_b;
                    FN_AND:  w_alu_res = w_op_a & w_alu_b;
                    FN_OR:   w_alu_res = w_op_a | w_alu_b;
                    FN_SLT:  w_alu_res = {{(DATA_W-1){1'b0}},
                                          ($signed(w_op_a) < $signed(w_alu_b))};
                    FN_XOR:  w_alu_res = w_op_a ^ w_alu_b;
                    FN_MUL:  w_alu_res = '0;
                    FN_NOR:  w_alu_res = ~(w_op_a | w_alu_b);
                    default: w_alu_res = '0;
                endcase
            end
            default:   w_alu_res = w_op_a + w_alu_b;
        endcase
    end

`ifdef EX_MUL_EN
    logic              w_is_mul;
    logic              w_mul_start;
    logic              w_mul_busy;
    logic              w_mul_last;
    logic [DATA_W-1:0] w_mul_res;

    assign w_is_mul    = (alu_op == ALU_FUNCT) && (w_funct == FN_MUL);
    assign w_mul_start = in_valid && w_is_mul;

    ex_mul_seq #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_start  (w_mul_start),
        .i_flush  (flush),
        .i_a      (w_op_a),
        .i_b      (w_alu_b),
        .o_busy   (w_mul_busy),
        .o_last   (w_mul_last),
        .o_result (w_mul_res)
    );

    // Stall from acceptance through the second-to-last BUSY cycle
    always_comb begin
        w_stall  = (!w_mul_busy && w_mul_start && !flush) ||
                   (w_mul_busy && !w_mul_last);
        w_result = w_mul_last ? w_mul_res : w_alu_res;
    end
`else
    assign w_stall  = 1'b0;
    assign w_result = w_alu_res;
`endif

    // EX/MEM register: bubble while stalled, data holds until stall drops
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_store  <= '0;
            r_rd     <= '0;
            r_zero   <= 1'b0;
            r_branch <= '0;
        end else begin
            r_valid <= in_valid && !w_stall && !flush;
            if (!w_stall) begin
                r_result <= w_result;
                r_store  <= w_fwd_b;
                r_rd     <= reg_dest ? rd_idx : rt_idx;
                r_zero   <= (w_result == '0);
                r_branch <= w_branch;
            end
        end
    end

    assign stall             = w_stall;
    assign out_valid         = r_valid;
    assign out_result        = r_result;
    assign out_store_data    = r_store;
    assign out_rd            = r_rd;
    assign out_zero          = r_zero;
    assign out_branch_target = r_branch;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Scoreboard bench for ex_stage_pipe (DATA_W=16, REG_W=3).
// Expectations adapt to whether EX_MUL_EN is defined.
module tb_ex_stage_pipe;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        flush;
    logic [15:0] pc_next;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic [15:0] imm;
    logic [2:0]  rt_idx;
    logic [2:0]  rd_idx;
    logic        alu_src;
    logic        reg_dest;
    logic [1:0]  alu_op;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [15:0] mem_result;
    logic [15:0] wb_result;
    logic        stall;
    logic        out_valid;
    logic [15:0] out_result;
    logic [15:0] out_store_data;
    logic [2:0]  out_rd;
    logic        out_zero;
    logic [15:0] out_branch_target;

    typedef struct packed {
        logic [15:0] res;
        logic [15:0] store;
        logic [2:0]  rd;
        logic [15:0] bt;
    } exp_t;

    exp_t  q[$];
    string nq[$];
    int    checks = 0;
    int    errors = 0;

`ifdef EX_MUL_EN
    localparam int MUL_STALL = 16;
    localparam logic [15:0] MUL1 = 16'h0015;
    localparam logic [15:0] MUL2 = 16'hFFFE;
`else
    localparam int MUL_STALL = 0;
    localparam logic [15:0] MUL1 = 16'h0000;
    localparam logic [15:0] MUL2 = 16'h0000;
`endif

    ex_stage_pipe #(
        .DATA_W (16),
        .REG_W  (3)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .in_valid          (in_valid),
        .flush             (flush),
        .pc_next           (pc_next),
        .rs_data           (rs_data),
        .rt_data           (rt_data),
        .imm               (imm),
        .rt_idx            (rt_idx),
        .rd_idx            (rd_idx),
        .alu_src           (alu_src),
        .reg_dest          (reg_dest),
        .alu_op            (alu_op),
        .fwd_a             (fwd_a),
        .fwd_b             (fwd_b),
        .mem_result        (mem_result),
        .wb_result         (wb_result),
        .stall             (stall),
        .out_valid         (out_valid),
        .out_result        (out_result),
        .out_store_data    (out_store_data),
        .out_rd            (out_rd),
        .out_zero          (out_zero),
        .out_branch_target (out_branch_target)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: compare every valid EX/MEM entry against the scoreboard head
    always @(negedge clock) begin
        exp_t  e;
        string n;
        if (reset_n && out_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got out_result=%h, required no valid output", out_result);
            end else begin
                e = q.pop_front();
                n = nq.pop_front();
                if (out_result !== e.res || out_zero !== (e.res == 16'h0) ||
                    out_store_data !== e.store || out_rd !== e.rd ||
                    out_branch_target !== e.bt) begin
                    errors++;
                    $display("FAIL %s: got res=%h zero=%b store=%h rd=%0d bt=%h, required res=%h zero=%b store=%h rd=%0d bt=%h",
                             n, out_result, out_zero, out_store_data, out_rd, out_branch_target,
                             e.res, (e.res == 16'h0), e.store, e.rd, e.bt);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, got, req);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] fa, input logic [1:0] fb,
                         input logic src, input logic rdst,
                         input logic [15:0] rs, input logic [15:0] rt, input logic [15:0] im,
                         input logic [15:0] mem, input logic [15:0] wb, input logic [15:0] pc);
        alu_op = op; fwd_a = fa; fwd_b = fb; alu_src = src; reg_dest = rdst;
        rs_data = rs; rt_data = rt; imm = im; mem_result = mem; wb_result = wb;
        pc_next = pc; in_valid = 1'b1;
    endtask

    task automatic expect_out(input string nm, input logic [15:0] res, input logic [15:0] st,
                              input logic [2:0] rd, input logic [15:0] bt);
        exp_t e;
        e.res = res; e.store = st; e.rd = rd; e.bt = bt;
        q.push_back(e);
        nq.push_back(nm);
    endtask

    task automatic single();
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_mul(input string nm, input int exp_stall);
        int cnt = 0;
        bit done = 0;
        bit bad_valid = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clock);
            if (stall) begin
                cnt++;
                if (cnt > 1 && out_valid) bad_valid = 1;
            end else begin
                done = 1;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s_timeout: stall still high after 40 cycles, required low", nm);
        end
        chk({nm, "_stall_cycles"}, cnt, exp_stall);
        chk({nm, "_bubble"}, {31'b0, bad_valid}, 32'd0);
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
        pc_next = '0; rs_data = '0; rt_data = '0; imm = '0;
        rt_idx = 3'd5; rd_idx = 3'd3;
        alu_src = 1'b0; reg_dest = 1'b0; alu_op = 2'b00; fwd_a = 2'b00; fwd_b = 2'b00;
        mem_result = '0; wb_result = '0;

        #12;
        chk("reset_outputs", {out_valid, out_result, out_zero, out_rd, out_store_data != 0, out_branch_target != 0},
            32'd0);
        chk("reset_stall", {31'b0, stall}, 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;

        // sub via funct, result zero
        issue(2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 16'h0005, 16'h0005, 16'h0001, 16'h0, 16'h0, 16'h0100);
        expect_out("sub_zero", 16'h0000, 16'h0005, 3'd3, 16'h0102);
        single();
        // forward from MEM, add immediate -1, negative branch offset
        issue(2'b00, 2'b10, 2'b00, 1'b1, 1'b0, 16'h0000, 16'h00AA, 16'hFFFF, 16'h1234, 16'h0, 16'h0010);
        expect_out("fwd_mem_addi", 16'h1233, 16'h00AA, 3'd5, 16'h000E);
        single();
        // signed slt
        issue(2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 16'h8000, 16'h0001, 16'h0004, 16'h0, 16'h0, 16'h0200);
        expect_out("slt_signed", 16'h0001, 16'h0001, 3'd3, 16'h0208);
        single();
        // and with B forwarded from WB
        issue(2'b10, 2'b00, 2'b01, 1'b0, 1'b1, 16'h00FF, 16'h7777, 16'h0002, 16'h0, 16'h0F0F, 16'h0000);
        expect_out("and_fwd_wb", 16'h000F, 16'h0F0F, 3'd3, 16'h0004);
        single();
        // sub wrap, A from WB, store data from MEM
        issue(2'b01, 2'b01, 2'b10, 1'b1, 1'b0, 16'h7777, 16'h0000, 16'h0003, 16'h4444, 16'h0002, 16'h1000);
        expect_out("sub_wrap", 16'hFFFF, 16'h4444, 3'd5, 16'h1006);
        single();
        // nor, xor, or back-to-back
        issue(2'b10, 2'b11, 2'b11, 1'b0, 1'b1, 16'h0F0F, 16'h00F0, 16'h0007, 16'h0, 16'h0, 16'h0000);
        expect_out("nor", 16'hF000, 16'h00F0, 3'd3, 16'h000E);
        @(posedge clock); #1;
        issue(2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 16'hFFFF, 16'h0F0F, 16'h0005, 16'h0, 16'h0, 16'h0020);
        expect_out("xor", 16'hF0F0, 16'h0F0F, 3'd3, 16'h002A);
        @(posedge clock); #1;
        issue(2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 16'h1200, 16'h0034, 16'h0003, 16'h0, 16'h0, 16'h0000);
        expect_out("or", 16'h1234, 16'h0034, 3'd5, 16'h0006);
        single();

        // multiplies
        issue(2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 16'h0003, 16'h0007, 16'h0006, 16'h0, 16'h0, 16'h0000);
        expect_out("mul_3x7", MUL1, 16'h0007, 3'd3, 16'h000C);
        run_mul("mul_3x7", MUL_STALL);
        issue(2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 16'hFFFF, 16'h0002, 16'h0006, 16'h0, 16'h0, 16'h0000);
        expect_out("mul_wrap", MUL2, 16'h0002, 3'd3, 16'h000C);
        run_mul("mul_wrap", MUL_STALL);

        // flush together with a mul request: not accepted
        issue(2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 16'h0003, 16'h0007, 16'h0006, 16'h0, 16'h0, 16'h0000);
        flush = 1'b1;
        @(negedge clock);
        chk("flush_req_stall", {31'b0, stall}, 32'd0);
        @(posedge clock); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clock);
        chk("flush_req_state", {30'b0, stall, out_valid}, 32'd0);
        issue(2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 16'h0011, 16'h0022, 16'h0000, 16'h0, 16'h0, 16'h0040);
        expect_out("add_after_flush_req", 16'h0033, 16'h0022, 3'd3, 16'h0040);
        single();

`ifdef EX_MUL_EN
        // flush five cycles into a multiply
        issue(2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 16'h0003, 16'h0007, 16'h0006, 16'h0, 16'h0, 16'h0000);
        repeat (5) @(negedge clock);
        chk("mid_flush_busy", {31'b0, stall}, 32'd1);
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clock);
        chk("mid_flush_idle", {30'b0, stall, out_valid}, 32'd0);
        issue(2'b11, 2'b00, 2'b11, 1'b0, 1'b0, 16'h0100, 16'h0001, 16'h0000, 16'h0, 16'h0, 16'h0002);
        expect_out("add_after_mid_flush", 16'h0101, 16'h0001, 3'd5, 16'h0002);
        single();

        // reset mid-multiply
        issue(2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 16'h0003, 16'h0007, 16'h0006, 16'h0, 16'h0, 16'h0000);
        repeat (3) @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("reset_mid_mul", {out_valid, stall, out_result, out_zero, out_rd, out_store_data != 0,
                              out_branch_target != 0}, 32'd0);
        in_valid = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
`endif

        // reset while an entry is valid
        issue(2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 16'h0001, 16'h0002, 16'h0004, 16'h0, 16'h0, 16'h0030);
        @(posedge clock); #1;
        in_valid = 1'b0;
        chk("valid_before_reset", {31'b0, out_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("reset_with_valid", {out_valid, out_result, out_zero, out_rd, out_store_data != 0,
                                 out_branch_target != 0}, 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;

        issue(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 16'h4000, 16'h4000, 16'h0000, 16'h0, 16'h0, 16'h0050);
        expect_out("add_after_reset", 16'h8000, 16'h4000, 3'd5, 16'h0050);
        single();

        repeat (3) @(posedge clock);
        chk("scoreboard_drained", q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_stage_pipe.md
# ex_stage_pipe

Parametrised execute stage for the pipelined processor: forwarding muxes, ALU with funct decode, branch-target adder, optional iterative multiplier and a registered EX/MEM output boundary. Sits between the ID/EX register and the MEM stage. Adds configurable width, multi-cycle operation with stall handshake, flush and reset to the existing execute path.

## Interface
- DATA_W, 16, datapath and PC width (≥8)
- REG_W, 3, register index width
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction present in EX
- flush  in  1  kill the instruction in EX, including an in-flight multiply
- pc_next  in  DATA_W  PC of the following instruction
- rs_data, rt_data  in  DATA_W  register-file operands
- imm  in  DATA_W  sign-extended immediate; imm[2:0] is funct
- rt_idx, rd_idx  in  REG_W  destination candidates
- alu_src  in  1  1: ALU B = imm
- reg_dest  in  1  1: destination = rd_idx
- alu_op  in  2  00 add, 01 sub, 10 funct, 11 add
- fwd_a, fwd_b  in  2  00 register, 01 wb_result, 10 mem_result, 11 register
- mem_result, wb_result  in  DATA_W  forwarding sources
- stall  out  1  upstream must hold its outputs and the ID/EX register
- out_valid  out  1  EX/MEM entry valid
- out_result  out  DATA_W  ALU or multiply result
- out_store_data  out  DATA_W  forwarded rt value
- out_rd  out  REG_W  destination index
- out_zero  out  1  out_result == 0
- out_branch_target  out  DATA_W  pc_next + (imm << 1), modulo 2^DATA_W

## Operation
- Operand A = fwd_a mux. Forwarded B = fwd_b mux. ALU B = alu_src ? imm : forwarded B. out_store_data = forwarded B.
- Funct values: 000 add, 001 sub, 010 and, 011 or, 100 slt (signed, result 0/1), 101 xor, 110 mul, 111 nor.
- Add, sub and multiply wrap modulo 2^DATA_W. Multiply returns the low DATA_W bits of the unsigned product.
- Multiplier FSM states:
  - IDLE → BUSY when in_valid & mul & ~flush. Operand A and ALU B are latched on that edge, so later forwarding changes are ignored.
  - BUSY performs one shift-add step per cycle for DATA_W cycles, then returns to IDLE and writes the EX/MEM register.
  - BUSY → IDLE immediately on flush; the product is discarded.
- stall = (IDLE & in_valid & mul & ~flush) | (BUSY & count != DATA_W-1).
- EX/MEM register updates every cycle:
  - out_valid ← in_valid & ~stall & ~flush.
  - Data fields load whenever stall is low, else hold.
  - While stalled, out_valid = 0 (bubble).

## Timing
- Reset (asynchronous): every out_* register = 0, FSM = IDLE, count = 0, stall = 0.
- Single-cycle ops: result on out_* one edge after the cycle in_valid is seen.
- Multiply: accepted at edge E0. stall is high for DATA_W cycles (the acceptance cycle plus DATA_W-1 BUSY cycles) and low in the final BUSY cycle. The result appears on out_* after edge E_DATA_W (DATA_W+1 edges after in_valid).
- Upstream holds its inputs stable while stall = 1. The stage does not re-accept the same mul because the FSM is BUSY.
- flush together with a mul request: not accepted, stall stays low.
- Reset mid-multiply: aborts to IDLE, no output.
- flush has priority over completion on the same edge.

## Configuration
- EX_MUL_EN defined: multiplier FSM and sub-module present, behaviour as above.
- EX_MUL_EN undefined: funct 110 returns 0 in a single cycle, stall is tied to 0, and no FSM is synthesised.

## Structure
- Package ex_pkg holds:
  - ALU op and funct localparams
  - forwarding select encodings
  - FSM state typedef (IDLE, BUSY)
- Sub-module ex_mul_seq contains the shift-add multiplier with start, busy and done handshake, parametrised by DATA_W.
- Muxes, ALU, adder and the output register stay in the top level.

## Test plan
- alu_op=10, funct 001, rs=0x0005, rt=0x0005 → out_result=0x0000, out_zero=1, out_valid=1 one edge later.
- fwd_a=10, mem_result=0x1234, alu_src=1, imm=0xFFFF, alu_op=00 → out_result=0x1233. pc_next=0x0010 → out_branch_target=0x000E.
- funct 100, rs=0x8000, rt=0x0001 → out_result=0x0001 (signed slt).
- With EX_MUL_EN: mul 0x0003×0x0007 → stall high for exactly 16 cycles, out_valid low during them, then out_result=0x0015. 0xFFFF×0x0002 → 0xFFFE.
- Flush 5 cycles into a multiply → stall drops on the next edge, FSM returns to IDLE, out_valid stays 0, and a following add completes normally.
- Assert reset_n low mid-multiply and with out_valid=1 → all outputs 0 immediately. Without EX_MUL_EN, mul gives out_result=0 and stall never rises.
